// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
//   - parity mode encodings seen on the parity_mode input
//   - transmitter FSM state encoding
//   - clamp limits for the data-width and stop-bit configuration
//   - helpers that turn raw configuration inputs into usable values
package uart_pkg;

  localparam int unsigned DATA_W_MIN = 5;
  localparam int unsigned MAX_STOP   = 3;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Clamp a requested data width into [DATA_W_MIN, max_w].
  function automatic logic [3:0] clamp_data_bits(logic [3:0] req, int unsigned max_w);
    logic [3:0] res;
    if (req < 4'(DATA_W_MIN)) begin
      res = 4'(DATA_W_MIN);
    end else if (req > 4'(max_w)) begin
      res = 4'(max_w);
    end else begin
      res = req;
    end
    return res;
  endfunction

  // A stop-bit count of 0 means 1; anything above MAX_STOP saturates.
  function automatic logic [1:0] clamp_stop_bits(logic [1:0] req);
    logic [1:0] res;
    if (req == 2'd0) begin
      res = 2'd1;
    end else if (req > 2'(MAX_STOP)) begin
      res = 2'(MAX_STOP);
    end else begin
      res = req;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO, Width bits x Depth entries (Depth a power of 2, >= 2).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (empties the FIFO)
//   push_i       write request; ignored while full
//   wdata_i      word to write
//   pop_i        read request; ignored while empty
//   rdata_o      head-of-FIFO word (valid while !empty_o)
//   full_o       level == Depth
//   empty_o      level == 0
//   level_o      current occupancy
module uart_tx_fifo #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 4,
  parameter int unsigned LvlW  = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LvlW-1:0]  level_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [LvlW-1:0]  level_q;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);
  // Fullness is judged before any same-cycle pop, so a write at full is dropped.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because Depth is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LvlW'(1);
        2'b01:   level_q <= level_q - LvlW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with input FIFO.
// Frame: start(0), 5..DATA_W_MAX data bits (LSB or MSB first), optional parity,
// 1..3 stop bits(1). Each bit lasts max(divisor,1) clk cycles. Frames are sent
// back-to-back while the FIFO holds data. Configuration is latched per word at pop.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tx_wr_ev          push strobe for tx_dat
//   tx_dat            data word (bits above data_bits ignored)
//   divisor           clk cycles per bit (0 treated as 1)
//   data_bits         data bits per frame (clamped to 5..DATA_W_MAX)
//   parity_mode       0 none, 1 even, 2 odd, 3 mark, 4 space, else none
//   stop_bit_num      stop bits (0 treated as 1)
//   trans_bit_order   0 LSB first, 1 MSB first
//   tx_dat_ser        registered serial line
//   tx_done_ev        pulse after the last stop bit of each frame
//   tx_ready          FIFO not full
//   tx_busy           frame in progress
//   tx_ovf_ev         pulse when a write hit a full FIFO
//   fifo_level        FIFO occupancy
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W_MAX = 9,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_wr_ev,
  input  logic [DATA_W_MAX-1:0] tx_dat,
  input  logic [DIV_W-1:0]      divisor,
  input  logic [3:0]            data_bits,
  input  logic [2:0]            parity_mode,
  input  logic [1:0]            stop_bit_num,
  input  logic                  trans_bit_order,
  output logic                  tx_dat_ser,
  output logic                  tx_done_ev,
  output logic                  tx_ready,
  output logic                  tx_busy,
  output logic                  tx_ovf_ev,
  output logic [LVL_W-1:0]      fifo_level
);

  localparam int unsigned IDX_W = $clog2(DATA_W_MAX);

  // FIFO
  logic                  fifo_pop;
  logic                  fifo_full, fifo_empty;
  logic [DATA_W_MAX-1:0] fifo_rdata;

  uart_tx_fifo #(
    .Width (DATA_W_MAX),
    .Depth (FIFO_DEPTH),
    .LvlW  (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_wr_ev),
    .wdata_i (tx_dat),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign tx_ready = ~fifo_full;

  // Configuration as it would be latched by a pop this cycle
  logic [3:0]            cfg_nbits;
  logic [1:0]            cfg_nstop;
  logic [DIV_W-1:0]      cfg_div;
  logic                  cfg_par_en;
  logic                  cfg_par_bit;
  logic [DATA_W_MAX-1:0] load_word;
  logic [IDX_W-1:0]      src_idx;

  assign cfg_nbits = clamp_data_bits(data_bits, DATA_W_MAX);
  assign cfg_nstop = clamp_stop_bits(stop_bit_num);
  assign cfg_div   = (divisor == '0) ? DIV_W'(1) : divisor;

  // The shifter always sends bit 0 first; MSB-first frames are reversed at load
  // time. Bits above the frame width are zeroed so parity sees only real data.
  always_comb begin
    load_word = '0;
    src_idx   = '0;
    for (int i = 0; i < int'(DATA_W_MAX); i++) begin
      if (i < int'(cfg_nbits)) begin
        src_idx      = trans_bit_order ? IDX_W'(int'(cfg_nbits) - 1 - i) : IDX_W'(i);
        load_word[i] = fifo_rdata[src_idx];
      end
    end
  end

  always_comb begin
    cfg_par_en  = 1'b1;
    cfg_par_bit = 1'b0;
    case (parity_mode)
      PAR_EVEN:  cfg_par_bit = ^load_word;
      PAR_ODD:   cfg_par_bit = ~(^load_word);
      PAR_MARK:  cfg_par_bit = 1'b1;
      PAR_SPACE: cfg_par_bit = 1'b0;
      default:   cfg_par_en  = 1'b0;
    endcase
  end

  // Transmit datapath and FSM state
  tx_state_e             state_q;
  logic [DIV_W-1:0]      baud_cnt_q;
  logic [3:0]            bit_cnt_q;
  logic [1:0]            stop_cnt_q;
  logic [DATA_W_MAX-1:0] shift_q;
  logic [3:0]            nbits_q;
  logic [1:0]            nstop_q;
  logic [DIV_W-1:0]      div_q;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ovf_q;

  logic [DIV_W-1:0] div_last;
  logic             baud_end;
  logic             bit_last;
  logic             stop_last;

  assign div_last  = div_q - DIV_W'(1);
  assign baud_end  = (baud_cnt_q == div_last);
  assign bit_last  = (bit_cnt_q == nbits_q - 4'd1);
  assign stop_last = (stop_cnt_q == nstop_q - 2'd1);

  // Pop when idle, or at the very end of a frame so the next start bit follows
  // the last stop bit with no idle cycle.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == StIdle) begin
        fifo_pop = 1'b1;
      end else if ((state_q == StStop) && baud_end && stop_last) begin
        fifo_pop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      nbits_q    <= 4'(DATA_W_MIN);
      nstop_q    <= 2'd1;
      div_q      <= DIV_W'(1);
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (fifo_pop) begin
        shift_q   <= load_word;
        nbits_q   <= cfg_nbits;
        nstop_q   <= cfg_nstop;
        div_q     <= cfg_div;
        par_en_q  <= cfg_par_en;
        par_bit_q <= cfg_par_bit;
      end

      unique case (state_q)
        StIdle: begin
          baud_cnt_q <= '0;
          if (fifo_pop) begin
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end

        StStart: begin
          if (baud_end) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= shift_q[0];
            shift_q    <= {1'b0, shift_q[DATA_W_MAX-1:1]};
            state_q    <= StData;
          end else begin
            baud_cnt_q <= baud_cnt_q + DIV_W'(1);
          end
        end

        StData: begin
          if (baud_end) begin
            baud_cnt_q <= '0;
            if (bit_last) begin
              if (par_en_q) begin
                tx_q    <= par_bit_q;
                state_q <= StParity;
              end else begin
                tx_q       <= 1'b1;
                stop_cnt_q <= '0;
                state_q    <= StStop;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[DATA_W_MAX-1:1]};
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + DIV_W'(1);
          end
        end

        StParity: begin
          if (baud_end) begin
            baud_cnt_q <= '0;
            tx_q       <= 1'b1;
            stop_cnt_q <= '0;
            state_q    <= StStop;
          end else begin
            baud_cnt_q <= baud_cnt_q + DIV_W'(1);
          end
        end

        StStop: begin
          if (baud_end) begin
            baud_cnt_q <= '0;
            if (stop_last) begin
              done_q <= 1'b1;
              if (fifo_pop) begin
                tx_q    <= 1'b0;
                state_q <= StStart;
              end else begin
                busy_q  <= 1'b0;
                state_q <= StIdle;
              end
            end else begin
              stop_cnt_q <= stop_cnt_q + 2'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + DIV_W'(1);
          end
        end

        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= tx_wr_ev & fifo_full;
    end
  end

  assign tx_dat_ser = tx_q;
  assign tx_done_ev = done_q;
  assign tx_busy    = busy_q;
  assign tx_ovf_ev  = ovf_q;

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

  localparam int DW    = 9;
  localparam int DIVW  = 16;
  localparam int DEPTH = 4;
  localparam int LVLW  = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            tx_wr_ev = 1'b0;
  logic [DW-1:0]   tx_dat = '0;
  logic [DIVW-1:0] divisor = 16'd4;
  logic [3:0]      data_bits = 4'd8;
  logic [2:0]      parity_mode = 3'd0;
  logic [1:0]      stop_bit_num = 2'd1;
  logic            trans_bit_order = 1'b0;
  logic            tx_dat_ser, tx_done_ev, tx_ready, tx_busy, tx_ovf_ev;
  logic [LVLW-1:0] fifo_level;

  uart_tx_param #(
    .DATA_W_MAX (DW),
    .DIV_W      (DIVW),
    .FIFO_DEPTH (DEPTH),
    .LVL_W      (LVLW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tx_wr_ev        (tx_wr_ev),
    .tx_dat          (tx_dat),
    .divisor         (divisor),
    .data_bits       (data_bits),
    .parity_mode     (parity_mode),
    .stop_bit_num    (stop_bit_num),
    .trans_bit_order (trans_bit_order),
    .tx_dat_ser      (tx_dat_ser),
    .tx_done_ev      (tx_done_ev),
    .tx_ready        (tx_ready),
    .tx_busy         (tx_busy),
    .tx_ovf_ev       (tx_ovf_ev),
    .fifo_level      (fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Captured DUT behaviour, one entry per cycle (sampled 1 time unit after posedge)
  logic got_line[$], got_done[$], got_busy[$], got_ovf[$], got_ready[$];
  logic [LVLW-1:0] got_level[$];
  // Reference waveform
  bit exp_line[$], exp_done[$], exp_busy[$];
  int done_idx[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int dv, input int nb, input int pm, input int sb, input int ord);
    divisor         = 16'(dv);
    data_bits       = 4'(nb);
    parity_mode     = 3'(pm);
    stop_bit_num    = 2'(sb);
    trans_bit_order = 1'(ord);
  endtask

  task automatic drive_write(input int word);
    tx_wr_ev = 1'b1;
    tx_dat   = 9'(word);
    tick();
    tx_wr_ev = 1'b0;
  endtask

  task automatic capture(input int n);
    got_line.delete(); got_done.delete(); got_busy.delete();
    got_ovf.delete(); got_ready.delete(); got_level.delete();
    for (int i = 0; i < n; i++) begin
      tick();
      got_line.push_back(tx_dat_ser);
      got_done.push_back(tx_done_ev);
      got_busy.push_back(tx_busy);
      got_ovf.push_back(tx_ovf_ev);
      got_ready.push_back(tx_ready);
      got_level.push_back(fifo_level);
    end
  endtask

  task automatic model_reset();
    exp_line.delete(); exp_done.delete(); exp_busy.delete(); done_idx.delete();
  endtask

  // Build the bit list of one frame from the frame rules, then stretch each bit.
  task automatic append_frame(input int word, input int dv, input int nb, input int pm,
                              input int sb, input int ord);
    int d, n, s, ones, b;
    int bits[$];
    d = (dv == 0) ? 1 : dv;
    n = (nb < 5) ? 5 : ((nb > DW) ? DW : nb);
    s = (sb == 0) ? 1 : sb;
    ones = 0;
    bits.push_back(0);
    for (int k = 0; k < n; k++) begin
      b = (word >> (ord != 0 ? (n - 1 - k) : k)) & 1;
      ones += b;
      bits.push_back(b);
    end
    case (pm)
      1: bits.push_back(ones % 2);
      2: bits.push_back(1 - (ones % 2));
      3: bits.push_back(1);
      4: bits.push_back(0);
      default: ;
    endcase
    for (int k = 0; k < s; k++) bits.push_back(1);
    foreach (bits[i]) begin
      for (int r = 0; r < d; r++) begin
        exp_line.push_back(bits[i][0]);
        exp_busy.push_back(1'b1);
      end
    end
    done_idx.push_back(exp_line.size());
  endtask

  task automatic model_pad(input int n);
    while (exp_line.size() < n) begin
      exp_line.push_back(1'b1);
      exp_busy.push_back(1'b0);
    end
    for (int i = 0; i < n; i++) exp_done.push_back(1'b0);
    foreach (done_idx[k]) if (done_idx[k] < n) exp_done[done_idx[k]] = 1'b1;
  endtask

  function automatic int first_diff(input int n);
    for (int i = 0; i < n; i++) begin
      if (got_line[i] !== exp_line[i] || got_done[i] !== exp_done[i] ||
          got_busy[i] !== exp_busy[i]) return i;
    end
    return -1;
  endfunction

  function automatic int first_done();
    foreach (got_done[i]) if (got_done[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_ovf();
    int c = 0;
    foreach (got_ovf[i]) if (got_ovf[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic test_reset();
    n_checks++;
    if (tx_dat_ser !== 1'b1) $display("FAIL reset_line: got %b want 1", tx_dat_ser);
    else n_pass++;
    n_checks++;
    if (fifo_level !== '0) $display("FAIL reset_level: got %0d want 0", fifo_level);
    else n_pass++;
    n_checks++;
    if ({tx_ready, tx_busy, tx_done_ev, tx_ovf_ev} !== 4'b1000)
      $display("FAIL reset_flags: ready/busy/done/ovf got %b want 1000",
               {tx_ready, tx_busy, tx_done_ev, tx_ovf_ev});
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int d;
    set_cfg(4, 8, 0, 1, 0);
    drive_write(9'h0A5);
    drive_write(9'h03C);
    drive_write(9'h0F0);
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_dat_ser !== 1'b1) $display("FAIL midreset_line: got %b want 1", tx_dat_ser);
    else n_pass++;
    n_checks++;
    if (fifo_level !== '0 || tx_ready !== 1'b1)
      $display("FAIL midreset_fifo: level %0d ready %b want 0 1", fifo_level, tx_ready);
    else n_pass++;
    n_checks++;
    if (tx_busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", tx_busy);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    capture(60);
    d = first_done();
    n_checks++;
    if (d != -1) $display("FAIL midreset_no_done: done pulse at cycle %0d want none", d);
    else n_pass++;
    model_reset();
    model_pad(60);
    d = first_diff(60);
    n_checks++;
    if (d != -1)
      $display("FAIL midreset_idle: cycle %0d line/done/busy got %b%b%b want %b%b%b", d,
               got_line[d], got_done[d], got_busy[d], exp_line[d], exp_done[d], exp_busy[d]);
    else n_pass++;
  endtask

  task automatic test_8n1_lsb();
    int n, d;
    set_cfg(4, 8, 0, 1, 0);
    model_reset();
    append_frame(9'h0A5, 4, 8, 0, 1, 0);
    n = 48;
    model_pad(n);
    drive_write(9'h0A5);
    capture(n);
    d = first_diff(n);
    n_checks++;
    if (d != -1)
      $display("FAIL 8n1_wave: cycle %0d line/done/busy got %b%b%b want %b%b%b", d,
               got_line[d], got_done[d], got_busy[d], exp_line[d], exp_done[d], exp_busy[d]);
    else n_pass++;
    d = first_done();
    n_checks++;
    if (d != 40) $display("FAIL 8n1_done_time: got cycle %0d want 40", d);
    else n_pass++;
  endtask

  task automatic test_7e2_msb();
    int n, d;
    set_cfg(3, 7, 1, 2, 1);
    model_reset();
    append_frame(9'h035, 3, 7, 1, 2, 1);
    n = 40;
    model_pad(n);
    drive_write(9'h035);
    capture(n);
    d = first_diff(n);
    n_checks++;
    if (d != -1)
      $display("FAIL 7e2_wave: cycle %0d line/done/busy got %b%b%b want %b%b%b", d,
               got_line[d], got_done[d], got_busy[d], exp_line[d], exp_done[d], exp_busy[d]);
    else n_pass++;
    d = first_done();
    n_checks++;
    if (d != 33) $display("FAIL 7e2_frame_len: got %0d want 33", d);
    else n_pass++;
  endtask

  task automatic test_clamps();
    int n, d, w;
    // 9 data bits, odd parity, all ones
    set_cfg(2, 9, 2, 1, 0);
    model_reset();
    append_frame(9'h1FF, 2, 9, 2, 1, 0);
    n = exp_line.size() + 6;
    model_pad(n);
    drive_write(9'h1FF);
    capture(n);
    n_checks++;
    if (got_line[20] !== 1'b0) $display("FAIL 9o1_parity: got %b want 0", got_line[20]);
    else n_pass++;
    d = first_diff(n);
    n_checks++;
    if (d != -1)
      $display("FAIL 9o1_wave: cycle %0d line/done/busy got %b%b%b want %b%b%b", d,
               got_line[d], got_done[d], got_busy[d], exp_line[d], exp_done[d], exp_busy[d]);
    else n_pass++;
    // data_bits=3 clamps to 5
    w = $urandom_range(0, 511);
    set_cfg(2, 3, 0, 1, 0);
    model_reset();
    append_frame(w, 2, 3, 0, 1, 0);
    n = exp_line.size() + 6;
    model_pad(n);
    drive_write(w);
    capture(n);
    d = first_done();
    n_checks++;
    if (d != 14) $display("FAIL clamp5_len: got %0d want 14", d);
    else n_pass++;
    d = first_diff(n);
    n_checks++;
    if (d != -1)
      $display("FAIL clamp5_wave: cycle %0d line/done/busy got %b%b%b want %b%b%b", d,
               got_line[d], got_done[d], got_busy[d], exp_line[d], exp_done[d], exp_busy[d]);
    else n_pass++;
    // divisor=0 behaves as 1
    w = $urandom_range(0, 511);
    set_cfg(0, 8, 1, 1, 0);
    model_reset();
    append_frame(w, 0, 8, 1, 1, 0);
    n = exp_line.size() + 6;
    model_pad(n);
    drive_write(w);
    capture(n);
    d = first_done();
    n_checks++;
    if (d != 11) $display("FAIL div0_len: got %0d want 11", d);
    else n_pass++;
    d = first_diff(n);
    n_checks++;
    if (d != -1)
      $display("FAIL div0_wave: cycle %0d line/done/busy got %b%b%b want %b%b%b", d,
               got_line[d], got_done[d], got_busy[d], exp_line[d], exp_done[d], exp_busy[d]);
    else n_pass++;
  endtask

  task automatic test_random_frames();
    int n, d, w, dv, nb, pm, sb, ord;
    for (int t = 0; t < 10; t++) begin
      w   = $urandom_range(0, 511);
      dv  = $urandom_range(0, 4);
      nb  = $urandom_range(0, 15);
      pm  = $urandom_range(0, 7);
      sb  = $urandom_range(0, 3);
      ord = $urandom_range(0, 1);
      set_cfg(dv, nb, pm, sb, ord);
      model_reset();
      append_frame(w, dv, nb, pm, sb, ord);
      n = exp_line.size() + 5;
      model_pad(n);
      drive_write(w);
      capture(n);
      d = first_diff(n);
      n_checks++;
      if (d != -1)
        $display("FAIL rand%0d_wave (w=%h dv=%0d nb=%0d pm=%0d sb=%0d ord=%0d): cycle %0d got %b%b%b want %b%b%b",
                 t, w, dv, nb, pm, sb, ord, d, got_line[d], got_done[d], got_busy[d],
                 exp_line[d], exp_done[d], exp_busy[d]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int n, d;
    int w[6];
    // Ordering A: writes start while idle; pops keep the FIFO below full.
    set_cfg(2, 8, 0, 1, 0);
    foreach (w[i]) w[i] = $urandom_range(0, 255);
    model_reset();
    for (int i = 0; i < 5; i++) append_frame(w[i], 2, 8, 0, 1, 0);
    n = exp_line.size() + 6;
    model_pad(n);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          tx_wr_ev = 1'b1;
          tx_dat   = 9'(w[i]);
          tick();
        end
        tx_wr_ev = 1'b0;
      end
      begin
        tick();
        capture(n);
      end
    join
    d = first_diff(n);
    n_checks++;
    if (d != -1)
      $display("FAIL b2b_a_wave: cycle %0d line/done/busy got %b%b%b want %b%b%b", d,
               got_line[d], got_done[d], got_busy[d], exp_line[d], exp_done[d], exp_busy[d]);
    else n_pass++;
    n_checks++;
    if (count_ovf() != 0) $display("FAIL b2b_a_ovf: got %0d pulses want 0", count_ovf());
    else n_pass++;

    // Ordering B: FSM already busy, so five writes fill the FIFO and the last is dropped.
    foreach (w[i]) w[i] = $urandom_range(0, 255);
    model_reset();
    for (int i = 0; i < 5; i++) append_frame(w[i], 2, 8, 0, 1, 0);
    n = exp_line.size() + 6;
    model_pad(n);
    drive_write(w[0]);
    fork
      begin
        tick();
        for (int i = 1; i < 6; i++) begin
          tx_wr_ev = 1'b1;
          tx_dat   = 9'(w[i]);
          tick();
        end
        tx_wr_ev = 1'b0;
      end
      capture(n);
    join
    d = first_diff(n);
    n_checks++;
    if (d != -1)
      $display("FAIL b2b_b_wave: cycle %0d line/done/busy got %b%b%b want %b%b%b", d,
               got_line[d], got_done[d], got_busy[d], exp_line[d], exp_done[d], exp_busy[d]);
    else n_pass++;
    n_checks++;
    if (count_ovf() != 1 || got_ovf[5] !== 1'b1)
      $display("FAIL b2b_b_ovf: pulses %0d, at cycle 5 %b; want 1 pulse at cycle 5",
               count_ovf(), got_ovf[5]);
    else n_pass++;
    n_checks++;
    if (got_level[5] !== 3'd4 || got_ready[4] !== 1'b0)
      $display("FAIL b2b_b_full: level %0d ready %b want 4 0", got_level[5], got_ready[4]);
    else n_pass++;
  endtask

  task automatic test_cfg_change();
    int n, d, w0, w1;
    w0 = $urandom_range(0, 255);
    w1 = $urandom_range(0, 255);
    set_cfg(2, 8, 0, 1, 0);
    model_reset();
    append_frame(w0, 2, 8, 0, 1, 0);
    append_frame(w1, 2, 8, 0, 3, 0);
    n = exp_line.size() + 6;
    model_pad(n);
    fork
      begin
        drive_write(w0);
        drive_write(w1);
        repeat (6) tick();
        stop_bit_num = 2'd3;
      end
      begin
        tick();
        capture(n);
      end
    join
    d = first_done();
    n_checks++;
    if (d != 20) $display("FAIL cfg_first_len: got %0d want 20", d);
    else n_pass++;
    d = first_diff(n);
    n_checks++;
    if (d != -1)
      $display("FAIL cfg_wave: cycle %0d line/done/busy got %b%b%b want %b%b%b", d,
               got_line[d], got_done[d], got_busy[d], exp_line[d], exp_done[d], exp_busy[d]);
    else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    test_reset();
    test_reset_mid_frame();
    test_8n1_lsb();
    test_7e2_msb();
    test_clamps();
    test_random_frames();
    test_back_to_back();
    test_cfg_change();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised next-generation UART transmitter with a small input FIFO.
- Serialises 5..DATA_W_MAX data bits per frame, LSB- or MSB-first.
- Supports none/even/odd/mark/space parity and 1-3 stop bits.
- Sends frames back-to-back with no idle gap while the FIFO holds data.
- Sits between the host register interface and the TX pad, with the same divisor-based baud timing as the existing UART blocks.

Parameters:
DATA_W_MAX, 9, widest data field supported (5..9); also the FIFO entry width.
DIV_W, 16, width of the divisor input.
FIFO_DEPTH, 4, TX FIFO entries; power of 2, at least 2.
LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_wr_ev  in  1  single-cycle write strobe; pushes tx_dat into the FIFO
tx_dat  in  DATA_W_MAX  data word; bits above data_bits are ignored
divisor  in  DIV_W  clk cycles per bit; 0 is treated as 1
data_bits  in  4  data bits per frame; <5 clamps to 5, >DATA_W_MAX clamps to DATA_W_MAX
parity_mode  in  3  0 none, 1 even, 2 odd, 3 mark(1), 4 space(0); 5-7 treated as none
stop_bit_num  in  2  stop bits; 0 is treated as 1
trans_bit_order  in  1  0 LSB first, 1 MSB first (MSB = bit data_bits-1)
tx_dat_ser  out  1  serial line, registered
tx_done_ev  out  1  one-cycle pulse at the end of each frame's last stop bit
tx_ready  out  1  FIFO not full (fifo_level != FIFO_DEPTH)
tx_busy  out  1  high from frame load until the FSM returns to IDLE
tx_ovf_ev  out  1  one-cycle pulse when a write arrives while the FIFO is full
fifo_level  out  LVL_W  current FIFO occupancy

Behaviour:
- Reset (rst_n=0, async):
  - FSM=IDLE, tx_dat_ser=1, tx_done_ev=0, tx_busy=0, tx_ovf_ev=0, fifo_level=0, tx_ready=1.
  - All counters clear.
  - Reset mid-frame aborts the frame; the line returns to 1 immediately and FIFO contents are discarded.
- FIFO push/pop:
  - Push on tx_wr_ev && tx_ready.
  - Write while full: word dropped, tx_ovf_ev=1 for one cycle, level unchanged. Applies even if a pop occurs in the same cycle; tx_ready is evaluated before the pop.
  - Push and pop in the same cycle: level unchanged.
- Config latch: divisor, data_bits, parity_mode, stop_bit_num and trans_bit_order are latched with the data word at each pop. Changes mid-frame do not affect the current frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop, load the shift register, tx_dat_ser<=0, tx_busy<=1 -> START.
  - START: after divisor cycles, drive the first data bit -> DATA.
  - DATA: each bit is held exactly divisor cycles. After data_bits bits go to PARITY if parity is enabled, otherwise STOP. tx_dat_ser is updated on the bit boundary edge, never mid-bit.
  - PARITY: drive the parity bit for divisor cycles -> STOP.
    - even = XOR of the data_bits data bits; odd = its inverse; mark = 1; space = 0.
  - STOP: drive 1 for stop_bit_num*divisor cycles. On the final edge tx_done_ev=1, then:
    - FIFO non-empty: pop and go straight to START (tx_dat_ser<=0, no idle cycle, tx_busy stays 1).
    - FIFO empty: go to IDLE, tx_busy<=0.
- Latency: write at edge E0 into an empty FIFO with the FSM idle -> fifo_level=1 after E0 -> pop at E1, tx_dat_ser=0 from E1.
- Frame length: divisor*(1+data_bits+P+stop_bit_num) cycles, P = 1 if parity enabled, else 0.
- Counters:
  - Baud counter is DIV_W bits, compared against eff_div-1; it never wraps past that.
  - Bit counter is 4 bits.
  - Stop counter is 2 bits.
  - FIFO pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package uart_pkg:
  - parity mode constants PAR_NONE/EVEN/ODD/MARK/SPACE;
  - FSM state encoding;
  - clamp constants DATA_W_MIN=5 and MAX_STOP=3.
- Sub-module uart_tx_fifo: sync FIFO of DATA_W_MAX x FIFO_DEPTH with push/pop/full/empty/level and async active-low reset.
- Baud counter, shifter and FSM stay in the top.

Test Plan:
1. Reset values: rst_n low mid-frame, divisor=4 -> tx_dat_ser=1, fifo_level=0, tx_ready=1 within the reset cycle; no tx_done_ev afterwards.
2. 8N1 LSB: divisor=4, data_bits=8, parity none, stop=1, write 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done_ev at cycle 40 after start.
3. 7E2 MSB: divisor=3, data_bits=7, even parity, stop=2, order=1, write 0x35 -> data 0,1,1,0,1,0,1; parity 0; two stop bits; frame 33 cycles.
4. 9O1 and clamps: data_bits=9, odd parity, write 0x1FF -> parity bit 0. Repeat with data_bits=3 -> frame uses 5 bits. Repeat with divisor=0 -> 1 cycle per bit.
5. Back-to-back and full: FIFO_DEPTH=4, divisor=2, write 5 words in 5 consecutive cycles.
   - 5th write: if it arrives while the FIFO holds 4 words, tx_ovf_ev pulses and the word is dropped; otherwise it is accepted. Check both orderings.
   - Frames are contiguous: no idle cycle between the stop bit and the next start bit; tx_busy stays high until the last frame ends.
6. Config change mid-frame: switch stop_bit_num 1->3 during DATA -> current frame keeps 1 stop bit; the next frame uses 3.
